// File: rtl/ir_logic_pkg.sv
// Shared opcode set, accumulate FSM states and helpers for the ir_logic_unit block.
package ir_logic_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_NAND = 4'd1,
    OP_OR   = 4'd2,
    OP_NOR  = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_INV  = 4'd8,
    OP_RAND = 4'd9,
    OP_ROR  = 4'd10,
    OP_RXOR = 4'd11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  // Identity element bit replicated across the word when a packet starts
  localparam logic IDENT_ONES = 1'b1;
  localparam logic IDENT_ZERO = 1'b0;

  function automatic logic is_reserved(input logic [3:0] op);
    return op >= 4'd12;
  endfunction

  function automatic logic is_accum_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  function automatic logic ident_bit(input logic [3:0] op);
    return (op == OP_AND) ? IDENT_ONES : IDENT_ZERO;
  endfunction

endpackage

// File: rtl/ir_logic_core.sv
// Combinational evaluation of one logic opcode on N-bit operands.
module ir_logic_core
  import ir_logic_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [3:0]    op,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [SW-1:0] sh,
  output logic [N-1:0]  res_c,
  output logic          flag_c,
  output logic          reserved_c
);

  // Only reachable for non-power-of-2 widths
  logic sh_ovf;
  assign sh_ovf = 32'(sh) >= N;

  always_comb begin
    res_c = '0;
    case (op)
      OP_AND:  res_c = a & b;
      OP_NAND: res_c = ~(a & b);
      OP_OR:   res_c = a | b;
      OP_NOR:  res_c = ~(a | b);
      OP_XOR:  res_c = a ^ b;
      OP_XNOR: res_c = ~(a ^ b);
      OP_SHL:  res_c = sh_ovf ? '0 : (a << sh);
      OP_SHR:  res_c = sh_ovf ? '0 : (a >> sh);
      OP_INV:  res_c = ~a;
      OP_RAND: res_c = N'(&a);
      OP_ROR:  res_c = N'(|a);
      OP_RXOR: res_c = N'(^a);
      default: res_c = '0;
    endcase
    // Reductions place r in bit 0, so |C equals r for them as well
    flag_c     = |res_c;
    reserved_c = is_reserved(op);
  end

endmodule

// File: rtl/ir_logic_unit.sv
// Pipelined logic unit with valid/ready handshake and registered result.
// Define IR_LOGIC_ACCUM_EN to build the packet accumulate FSM and ACCV register.
module ir_logic_unit
  import ir_logic_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [3:0]    OP,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [SW-1:0] SH,
  input  logic          ACC,
  input  logic          LAST,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [N-1:0]  C,
  output logic          R,
  output logic          ERR
);

  logic [N-1:0] core_res;
  logic         core_flag;
  logic         core_reserved;

  ir_logic_core #(.N(N)) u_core (
    .op         (OP),
    .a          (A),
    .b          (B),
    .sh         (SH),
    .res_c      (core_res),
    .flag_c     (core_flag),
    .reserved_c (core_reserved)
  );

  logic accept;
  assign IN_READY = !OUT_VALID || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  logic         out_valid_d;
  logic [N-1:0] c_d;
  logic         r_d;
  logic         err_d;
  logic         produce;
  logic         normal;
  logic [N-1:0] res;
  logic         flag;

`ifdef IR_LOGIC_ACCUM_EN
  acc_state_e   state_q, state_d;
  logic [N-1:0] accv_q, accv_d;
  logic [3:0]   pkt_op_q, pkt_op_d;
  logic [N-1:0] acc_word;

  function automatic logic [N-1:0] fold(input logic [3:0] op, input logic [N-1:0] x,
                                        input logic [N-1:0] y);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      default: return x ^ y;
    endcase
  endfunction
`else
  logic unused_acc_ports;
  assign unused_acc_ports = ACC ^ LAST;
`endif

  // Next-state and next-output selection
  always_comb begin
    out_valid_d = OUT_VALID && !OUT_READY;
    c_d         = C;
    r_d         = R;
    err_d       = ERR;
    produce     = 1'b1;
    normal      = 1'b1;
    res         = core_res;
    flag        = core_flag;
`ifdef IR_LOGIC_ACCUM_EN
    state_d     = state_q;
    accv_d      = accv_q;
    pkt_op_d    = pkt_op_q;
    acc_word    = '0;
`endif
    if (accept) begin
`ifdef IR_LOGIC_ACCUM_EN
      case (state_q)
        ST_IDLE: begin
          if (ACC && is_accum_op(OP)) begin
            normal   = 1'b0;
            acc_word = fold(OP, {N{ident_bit(OP)}}, A);
            if (LAST) begin
              res  = acc_word;
              flag = |acc_word;
            end else begin
              produce  = 1'b0;
              accv_d   = acc_word;
              pkt_op_d = OP;
              state_d  = ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          // ACC=0 beats fall through as normal ops and leave the packet open
          if (ACC) begin
            normal   = 1'b0;
            acc_word = fold(pkt_op_q, accv_q, A);
            if (LAST) begin
              res     = acc_word;
              flag    = |acc_word;
              accv_d  = '0;
              state_d = ST_IDLE;
            end else begin
              produce = 1'b0;
              accv_d  = acc_word;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
`endif
      out_valid_d = produce;
      if (produce) begin
        c_d = res;
        r_d = flag;
      end
      if (normal && core_reserved) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      C         <= '0;
      R         <= 1'b0;
      ERR       <= 1'b0;
`ifdef IR_LOGIC_ACCUM_EN
      state_q   <= ST_IDLE;
      accv_q    <= '0;
      pkt_op_q  <= '0;
`endif
    end else begin
      OUT_VALID <= out_valid_d;
      C         <= c_d;
      R         <= r_d;
      ERR       <= err_d;
`ifdef IR_LOGIC_ACCUM_EN
      state_q   <= state_d;
      accv_q    <= accv_d;
      pkt_op_q  <= pkt_op_d;
`endif
    end
  end

endmodule

// File: doc/ir_logic_unit.md
# ir_logic_unit

Parametrised, pipelined bitwise logic unit with a valid/ready stream interface. It provides the full logic operation set in one block: and, nand, or, nor, xor, xnor, variable shifts, invert, and reductions. A packet accumulate mode folds a stream of operands into one result. It sits in the datapath wherever several fixed-width logic primitives would otherwise be instantiated side by side, and adds flow control and a registered output.

## Interface
- N, 8: operand width; legal N ≥ 2. Shift-amount width SW = $clog2(N) is derived, not a parameter.
- CLK  input  1  rising-edge clock; the only clock.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  input beat valid.
- IN_READY  output  1  unit can accept a beat.
- OP  input  4  opcode, defined in ir_logic_pkg.
- A  input  N  operand A.
- B  input  N  operand B; ignored by unary and shift ops.
- SH  input  SW  shift amount.
- ACC  input  1  beat belongs to an accumulate packet. Only used when IR_LOGIC_ACCUM_EN is defined.
- LAST  input  1  final beat of an accumulate packet.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.
- C  output  N  result word.
- R  output  1  flag bit: reduction result, or |C for word ops.
- ERR  output  1  sticky flag; set when a reserved opcode is accepted.

## Operation
- Opcodes:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 SHL: A<<SH, logical. 7 SHR: A>>SH, logical. If SH ≥ N (non-power-of-2 N), C=0.
  - 8 INV: ~A.
  - 9 RAND: &A. 10 ROR: |A. 11 RXOR: ^A, true parity.
  - 12–15 reserved.
- Reductions drive C = {N-1 zeros, r} and R = r.
- Word ops drive R = |C.
- Reserved opcodes drive C=0 and R=0, and set ERR. ERR clears only on RESET.
- A beat is accepted when IN_VALID && IN_READY.
- IN_READY = !OUT_VALID || OUT_READY, so a result can be consumed and a new beat accepted in the same cycle.
- Accumulate FSM has two states, IDLE and ACCUM. Only OP ∈ {AND, OR, XOR} participates.
  - IDLE, accepted beat with ACC=1, LAST=0, participating op: latch OP as PKT_OP. Set ACCV = ident(PKT_OP) op A, where ident is all-ones for AND and zero otherwise. Go to ACCUM. No output is produced.
  - IDLE, accepted beat with ACC=1, LAST=1: single-beat packet. C = ident op A is output; stay in IDLE.
  - ACCUM, accepted beat: ACCV = ACCV PKT_OP A. The beat's OP and B are ignored.
  - ACCUM, accepted beat with LAST=1: output C = final ACCV and R = |C, then return to IDLE.
  - ACC=1 with a non-participating OP in IDLE: the beat is processed as a normal op and the FSM is unaffected.
  - ACC=0 beat while in ACCUM: the beat is processed as a normal op and the packet stays open.
- RESET mid-packet discards ACCV and returns the FSM to IDLE.

## Timing
- Latency is 1 cycle: a beat accepted at edge k produces OUT_VALID from edge k; C and R are registered.
- Non-LAST accumulate beats produce no output and never stall, beyond the normal IN_READY rule.
- C and R hold stable while OUT_VALID && !OUT_READY.
- Reset values: OUT_VALID=0, C=0, R=0, ERR=0, FSM=IDLE, ACCV=0.
- IN_READY is 1 in the first cycle after reset.
- Full throughput is one beat per cycle with OUT_READY held at 1.

## Configuration
- IR_LOGIC_ACCUM_EN defined: accumulate FSM and ACCV register are present, with behaviour as above.
- IR_LOGIC_ACCUM_EN not defined:
  - ACC and LAST ports remain present but are ignored.
  - Every beat is a normal op producing an output.
  - No FSM and no ACCV register.

## Structure
- Package ir_logic_pkg holds:
  - Opcode enum (logic [3:0]) with named values OP_AND … OP_RXOR.
  - Function is_reserved(op) and function is_accum_op(op).
  - Localparams for the identity selection.
- Sub-module ir_logic_core: purely combinational evaluation of (OP, A, B, SH) → (C, R, reserved). It is parametrised by N.
- The top level holds handshake, output register, FSM and ERR.

## Test plan
- Reset, then OP=XOR, A=8'hF0, B=8'h3C, OUT_READY=1 → next cycle C=8'hCC, R=1, OUT_VALID=1.
- OP=RXOR, A=8'h07 → C=8'h01, R=1. OP=SHR, A=8'h80, SH=3 → C=8'h10.
- OUT_READY=0 for 3 cycles with back-to-back beats → IN_READY=0 after the first beat, C stable; releasing OUT_READY resumes 1 beat/cycle with no loss or duplication.
- Accumulate (EN defined): AND packet A=8'hFF, 8'h0F, 8'h3C with LAST on the third beat → single output C=8'h0C, R=1; no output on beats 1–2.
- RESET asserted mid-packet after 2 OR beats, then a new OR packet of one LAST beat A=8'h01 → C=8'h01. Stale ACCV must not leak into the result.
- OP=13 accepted → C=0, R=0, ERR=1 and held through later valid ops until RESET.
